// File: rtl/mux_merge.sv
// Two-input valid/ready stream merger with a registered output that tags each word with its source.
// Optional MUX_MERGE_FIXED_PRIO_EN: in0 always wins contention instead of round-robin.
module mux_merge #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel,
    input  logic             out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             can_load;
    logic             grant_valid;
    logic             g;
    logic             load;
    logic [WIDTH-1:0] data_q;
    logic             sel_q;

    assign grant_valid = in0_valid || in1_valid;

`ifdef MUX_MERGE_FIXED_PRIO_EN
    // in0 takes every contention; in1 only wins when in0 is idle
    assign g = !in0_valid;
`else
    logic last_grant;

    // Starts at 1 so in0 wins the first contention after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (load) begin
            last_grant <= g;
        end
    end

    assign g = (in0_valid && in1_valid) ? !last_grant : !in0_valid;
`endif

    assign can_load  = (state == EMPTY) || out_ready;
    assign load      = can_load && grant_valid;
    assign in0_ready = can_load && in0_valid && !g;
    assign in1_ready = can_load && in1_valid && g;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // A load always leaves the register full; a drain without a load empties it
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (load) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (!load && out_ready) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            sel_q  <= 1'b0;
        end else if (load) begin
            data_q <= g ? in1_data : in0_data;
            sel_q  <= g;
        end
    end

    assign out_valid = (state == FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule
